// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - LC-3 sequencer opcodes, state encoding and address-select codes
package lc3_pkg;

  // LC-3 opcodes (IR[15:12]); LDI and NOT occupy swapped slots in this core
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_LDI  = 4'b1001;
  localparam logic [3:0] OP_NOT  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSVD = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_W,
    ST_DECODE,
    ST_EXEC,
    ST_IND,
    ST_IND_W,
    ST_MEM,
    ST_MEM_W,
    ST_NEXT,
    ST_HALT
  } state_t;

  // BRAM address mux selects
  localparam logic [1:0] ASEL_PC  = 2'd0;
  localparam logic [1:0] ASEL_REL = 2'd1;
  localparam logic [1:0] ASEL_PTR = 2'd2;

endpackage

// File: rtl/lc3_seq_decode.sv
// rtl/lc3_seq_decode.sv - combinational opcode to execution-class decoder
module lc3_seq_decode
  import lc3_pkg::*;
#(
  parameter logic [7:0] HALT_VECT = 8'h25
) (
  input  logic [3:0] opcode,
  input  logic [7:0] trap_vect,
  output logic       cls_alu,
  output logic       cls_mem,
  output logic       cls_ind,
  output logic       cls_store,
  output logic       cls_halt,
  output logic       cls_illegal,
  output logic       cls_writes_reg
);

  // Map each opcode onto the flags the sequencer FSM branches on
  always_comb begin
    cls_alu        = 1'b0;
    cls_mem        = 1'b0;
    cls_ind        = 1'b0;
    cls_store      = 1'b0;
    cls_halt       = 1'b0;
    cls_illegal    = 1'b0;
    cls_writes_reg = 1'b0;
    case (opcode)
      OP_ADD, OP_AND, OP_NOT, OP_LEA: begin
        cls_alu        = 1'b1;
        cls_writes_reg = 1'b1;
      end
      OP_BR, OP_JMP, OP_JSR, OP_RTI: cls_alu = 1'b1;
      OP_LD, OP_LDR: begin
        cls_mem        = 1'b1;
        cls_writes_reg = 1'b1;
      end
      OP_ST, OP_STR: begin
        cls_mem   = 1'b1;
        cls_store = 1'b1;
      end
      OP_LDI: begin
        cls_ind        = 1'b1;
        cls_writes_reg = 1'b1;
      end
      OP_STI: begin
        cls_ind   = 1'b1;
        cls_store = 1'b1;
      end
      OP_RSVD: begin
        cls_halt    = 1'b1;
        cls_illegal = 1'b1;
      end
      OP_TRAP: begin
        // Only the halt vector stops the machine; other traps retire as no-ops
        if (trap_vect == HALT_VECT) cls_halt = 1'b1;
        else                        cls_alu  = 1'b1;
      end
      default: cls_alu = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_seq.sv
// rtl/lc3_seq.sv - LC-3 multi-cycle sequencer; LC3_SEQ_PERF_EN enables the retire/busy counters
module lc3_seq
  import lc3_pkg::*;
#(
  parameter int         DATA_W    = 16,
  parameter logic [7:0] HALT_VECT = 8'h25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_start,
  output logic [3:0]        opcode_out,
  output logic [8:0]        offset_out,
  output logic [DATA_W-1:0] ir,
  output logic [1:0]        addr_sel,
  output logic              mem_we,
  output logic              reg_we,
  output logic              nzp_ld,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [15:0]       instr_cnt
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] ptr;
  logic [1:0]        addr_sel_nxt;
  logic              fetch_start_nxt, mem_we_nxt, reg_we_nxt, nzp_ld_nxt;
  logic              busy_nxt, halted_nxt, illegal_nxt;
  logic              dec_alu, dec_mem, dec_ind, dec_store;
  logic              dec_halt, dec_illegal, dec_writes_reg;

  assign opcode_out = ir[15:12];
  assign offset_out = ir[8:0];

  lc3_seq_decode #(
    .HALT_VECT(HALT_VECT)
  ) u_decode (
    .opcode        (ir[15:12]),
    .trap_vect     (ir[7:0]),
    .cls_alu       (dec_alu),
    .cls_mem       (dec_mem),
    .cls_ind       (dec_ind),
    .cls_store     (dec_store),
    .cls_halt      (dec_halt),
    .cls_illegal   (dec_illegal),
    .cls_writes_reg(dec_writes_reg)
  );

  // Next state plus the values every registered output takes in that state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (run) state_nxt = ST_FETCH;
      ST_FETCH:   state_nxt = ST_FETCH_W;
      ST_FETCH_W: state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (dec_halt)      state_nxt = ST_HALT;
        else if (dec_ind)  state_nxt = ST_IND;
        else if (dec_mem)  state_nxt = ST_MEM;
        else               state_nxt = ST_EXEC;
      end
      ST_IND:     state_nxt = ST_IND_W;
      ST_IND_W:   state_nxt = ST_MEM;
      ST_MEM:     state_nxt = ST_MEM_W;
      // Loads spend the EXEC cycle presenting BRAM data for write-back
      ST_MEM_W:   state_nxt = ST_EXEC;
      ST_EXEC:    state_nxt = ST_NEXT;
      ST_NEXT:    state_nxt = run ? ST_FETCH : ST_IDLE;
      ST_HALT:    state_nxt = ST_HALT;
      default:    state_nxt = ST_IDLE;
    endcase

    addr_sel_nxt = ASEL_PC;
    case (state_nxt)
      ST_IND, ST_IND_W: addr_sel_nxt = ASEL_REL;
      ST_MEM, ST_MEM_W: addr_sel_nxt = dec_ind ? ASEL_PTR : ASEL_REL;
      default:          addr_sel_nxt = ASEL_PC;
    endcase

    fetch_start_nxt = (state_nxt == ST_NEXT);
    mem_we_nxt      = (state_nxt == ST_MEM) && dec_store;
    reg_we_nxt      = (state_nxt == ST_NEXT) && dec_writes_reg;
    nzp_ld_nxt      = reg_we_nxt;
    busy_nxt        = (state_nxt != ST_IDLE) && (state_nxt != ST_HALT);
    halted_nxt      = (state_nxt == ST_HALT);
    illegal_nxt     = illegal || ((state == ST_DECODE) && dec_illegal);
  end

  // State and Moore output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr_sel    <= ASEL_PC;
      fetch_start <= 1'b0;
      mem_we      <= 1'b0;
      reg_we      <= 1'b0;
      nzp_ld      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr_sel    <= addr_sel_nxt;
      fetch_start <= fetch_start_nxt;
      mem_we      <= mem_we_nxt;
      reg_we      <= reg_we_nxt;
      nzp_ld      <= nzp_ld_nxt;
      busy        <= busy_nxt;
      halted      <= halted_nxt;
      illegal     <= illegal_nxt;
    end
  end

  // Capture the instruction word and the indirect pointer from BRAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir  <= '0;
      ptr <= '0;
    end else begin
      if (state == ST_FETCH_W) ir  <= mem_rdata;
      if (state == ST_IND_W)   ptr <= mem_rdata;
    end
  end

`ifdef LC3_SEQ_PERF_EN
  logic [31:0] busy_cycles;

  // Retire count bumps on entry to NEXT; busy_cycles is read hierarchically
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt   <= 16'h0;
      busy_cycles <= 32'h0;
    end else begin
      if (state_nxt == ST_NEXT) instr_cnt <= instr_cnt + 16'h1;
      if (busy)                 busy_cycles <= busy_cycles + 32'h1;
    end
  end
`else
  assign instr_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_lc3_seq.sv
// tb/tb_lc3_seq.sv - self-checking bench for lc3_seq with a behavioural cycle model
module tb_lc3_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] mem_rdata;
  logic        fetch_start;
  logic [3:0]  opcode_out;
  logic [8:0]  offset_out;
  logic [15:0] ir;
  logic [1:0]  addr_sel;
  logic        mem_we, reg_we, nzp_ld, busy, halted, illegal;
  logic [15:0] instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] slot0 = 16'h0;
  logic [15:0] slot1 = 16'h0;
  logic [15:0] slot2 = 16'h0;
  logic [15:0] prev_ir = 16'h0;
  logic [15:0] exp_cnt = 16'h0;

  lc3_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mem_rdata  (mem_rdata),
    .fetch_start(fetch_start),
    .opcode_out (opcode_out),
    .offset_out (offset_out),
    .ir         (ir),
    .addr_sel   (addr_sel),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .nzp_ld     (nzp_ld),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;

  // BRAM model: one-cycle read latency, contents keyed by the address source
  always @(posedge clk)
    mem_rdata <= (addr_sel == 2'd2) ? slot2 : (addr_sel == 2'd1) ? slot1 : slot0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_icnt(input logic [15:0] c);
`ifdef LC3_SEQ_PERF_EN
    return c;
`else
    return 16'h0 & c;
`endif
  endfunction

  // Instruction latency FETCH..NEXT: plain 5, one memory access 7, indirect 9
  function automatic int lat_of(input logic [15:0] w);
    logic [3:0] o;
    o = w[15:12];
    if (o == 4'h9 || o == 4'hB) return 9;
    if (o == 4'h2 || o == 4'h3 || o == 4'h6 || o == 4'h7) return 7;
    return 5;
  endfunction

  function automatic bit is_store(input logic [15:0] w);
    return (w[15:12] == 4'h3) || (w[15:12] == 4'h7) || (w[15:12] == 4'hB);
  endfunction

  function automatic bit writes_reg(input logic [15:0] w);
    case (w[15:12])
      4'h1, 4'h5, 4'hA, 4'h2, 4'h6, 4'h9, 4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit halts(input logic [15:0] w);
    return (w[15:12] == 4'hD) || (w[15:12] == 4'hF && w[7:0] == 8'h25);
  endfunction

  // Address source for cycle k: the two cycles before the data-access cycle
  // of an indirect op use the relative address, the access cycles use ptr
  function automatic logic [1:0] exp_asel(input int lat, input int k);
    if (lat == 5) return 2'd0;
    if (lat == 7) return (k == 4 || k == 5) ? 2'd1 : 2'd0;
    if (k == 4 || k == 5) return 2'd1;
    if (k == 6 || k == 7) return 2'd2;
    return 2'd0;
  endfunction

  // Run one non-halting instruction from FETCH to NEXT, checking every cycle
  task automatic run_instr(input logic [15:0] w, input logic [15:0] p1, input logic [15:0] p2,
                           input int drop_k, output int fs_k);
    int lat;
    int acc;
    lat   = lat_of(w);
    acc   = lat - 3;
    slot0 = w;
    slot1 = p1;
    slot2 = p2;
    run   = 1'b1;
    fs_k  = 0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == drop_k) run = 1'b0;
      chk("busy", busy, 1);
      chk("halted", halted, 0);
      chk("addr_sel", addr_sel, exp_asel(lat, k));
      chk("mem_we", mem_we, (lat > 5 && k == acc && is_store(w)) ? 1 : 0);
      chk("fetch_start", fetch_start, (k == lat) ? 1 : 0);
      chk("reg_we", reg_we, (k == lat && writes_reg(w)) ? 1 : 0);
      chk("nzp_ld", nzp_ld, (k == lat && writes_reg(w)) ? 1 : 0);
      chk("ir", ir, (k >= 3) ? w : prev_ir);
      if (fetch_start && fs_k == 0) fs_k = k;
      if (k == lat) begin
        chk("opcode_out", opcode_out, w[15:12]);
        chk("offset_out", offset_out, w[8:0]);
        chk("instr_cnt", instr_cnt, exp_icnt(exp_cnt + 16'h1));
      end
    end
    prev_ir = w;
    exp_cnt = exp_cnt + 16'h1;
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_fetch_start", fetch_start, 0);
      chk("idle_addr_sel", addr_sel, 0);
      chk("idle_ir", ir, prev_ir);
      chk("idle_halted", halted, 0);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_ir", ir, 0);
      chk("rst_fetch_start", fetch_start, 0);
      chk("rst_instr_cnt", instr_cnt, 0);
    end
    rst_n   = 1'b1;
    prev_ir = 16'h0;
    exp_cnt = 16'h0;
  endtask

  // Instruction that must stop the machine after DECODE without a fetch pulse
  task automatic halt_instr(input logic [15:0] w, input logic exp_ill);
    slot0 = w;
    run   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("h_busy", busy, 1);
      chk("h_halted", halted, 0);
      chk("h_fetch_start", fetch_start, 0);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_fetch_start", fetch_start, 0);
      chk("halt_illegal", illegal, exp_ill);
      chk("halt_mem_we", mem_we, 0);
      chk("halt_reg_we", reg_we, 0);
      chk("halt_ir", ir, w);
      chk("halt_instr_cnt", instr_cnt, exp_icnt(exp_cnt));
    end
  endtask

  initial begin
    int fs;
    int nidle;
    logic [15:0] w;
    rst_n = 1'b0;
    run   = 1'b0;

    do_reset(5);
    check_idle(4);

    run_instr(16'h1021, 16'h0000, 16'h0000, 0, fs);
    chk("add_latency", fs, 5);
    chk("add_opcode", opcode_out, 4'b0001);
    run_instr(16'h9002, 16'h3010, 16'hBEEF, 0, fs);
    chk("ldi_latency", fs, 9);
    run_instr(16'h3005, 16'h0000, 16'h0000, 7, fs);
    chk("st_latency", fs, 7);
    chk("cnt_after_3", instr_cnt, exp_icnt(16'd3));
    check_idle(3);

    run_instr(16'h9123, 16'h4000, 16'h1234, 4, fs);
    chk("ldi_drop_latency", fs, 9);
    check_idle(4);

    for (int n = 0; n < 150; n++) begin
      do begin
        w = 16'($urandom);
      end while (halts(w));
      run_instr(w, 16'($urandom), 16'($urandom),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, lat_of(w))) : 0, fs);
      if (!run) begin
        nidle = int'($urandom_range(1, 3));
        check_idle(nidle);
      end
    end

    halt_instr(16'hF025, 1'b0);
    do_reset(2);
    check_idle(2);

    run_instr(16'hE1FF, 16'h0, 16'h0, 0, fs);
    halt_instr(16'hD000, 1'b1);
    do_reset(2);
    check_idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
